tank_motion_ctrl: RTL and testbench

//  Parametrised player-tank controller: moves a SPR_W x SPR_H sprite along a fixed row at a

---
 rtl/tank_motion_ctrl.sv | 135 +++++++++++++
 tb/tb_tank_motion_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tank_motion_ctrl.sv
// Player tank controller: tick-paced horizontal motion with clamping
// and an erase/redraw pixel stream toward the VGA adapter.
module tank_motion_ctrl #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 155,
  parameter int X_INIT   = 78,
  parameter int Y_POS    = 110,
  parameter int SPR_W    = 5,
  parameter int SPR_H    = 3,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 833333,
  parameter logic [COL_W-1:0] FG_COLOUR = COL_W'(2),
  parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             move_left,
  input  logic             move_right,
  output logic [X_W-1:0]   x_pos,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot,
  output logic             busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [X_W:0] XMIN_E = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] XMAX_E = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] STEP_E = (X_W+1)'(STEP);

  typedef enum logic [2:0] {
    S_START,
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } state_t;

  state_t state, state_n;

  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           pix_last;
  logic [X_W-1:0] tgt;
  logic [X_W:0]   x_ext, x_dec, x_inc, tgt_c;
  logic           move_ok;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Target computed one bit wider so neither bound can wrap.
  assign x_ext = {1'b0, x_pos};
  assign x_dec = (x_ext < XMIN_E + STEP_E) ? XMIN_E : x_ext - STEP_E;
  assign x_inc = (x_ext + STEP_E > XMAX_E) ? XMAX_E : x_ext + STEP_E;

  always_comb begin
    tgt_c = x_ext;
    unique case (1'b1)
      (move_left && !move_right): tgt_c = x_dec;
      (move_right && !move_left): tgt_c = x_inc;
      default:                    tgt_c = x_ext;
    endcase
  end

  assign move_ok  = tick && (tgt_c != x_ext);
  assign pix_last = (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      S_START:  state_n = S_DRAW;
      S_IDLE:   if (move_ok) state_n = S_ERASE;
      S_ERASE:  if (pix_last) state_n = S_UPDATE;
      S_UPDATE: state_n = S_DRAW;
      S_DRAW:   if (pix_last) state_n = S_IDLE;
      default:  state_n = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_START;
      x_pos <= X_W'(X_INIT);
      tgt   <= X_W'(X_INIT);
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && move_ok) tgt <= tgt_c[X_W-1:0];
      if (state == S_UPDATE) x_pos <= tgt;
      // Row-major scan, column fastest; counters idle at zero.
      if (state == S_ERASE || state == S_DRAW) begin
        if (col == CW'(SPR_W - 1)) begin
          col <= '0;
          if (row == RW'(SPR_H - 1)) row <= '0;
          else                       row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else begin
        col <= '0;
        row <= '0;
      end
    end
  end

  always_comb begin
    vga_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = BG_COLOUR;
    busy       = (state != S_IDLE);
    if (state == S_ERASE || state == S_DRAW) begin
      vga_plot = 1'b1;
      vga_x    = x_pos + X_W'(col);
      vga_y    = Y_W'(Y_POS) + Y_W'(row);
      if (state == S_DRAW) vga_colour = FG_COLOUR;
    end
  end

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Bench for tank_motion_ctrl: directed scenarios plus random keys/resets
// compared cycle by cycle against a queue-based reference model.
module tb_tank_motion_ctrl;

  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic [7:0] x_pos, vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       busy;
    logic [7:0] xpos;
  } rec_t;

  rec_t q[$];
  int   ref_x = 5;
  int   ph = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   known = 1'b0;

  always #5 clk = ~clk;

  tank_motion_ctrl #(
    .X_W(8), .Y_W(7), .COL_W(3),
    .X_MIN(2), .X_MAX(10), .X_INIT(5), .Y_POS(3),
    .SPR_W(2), .SPR_H(2), .STEP(1), .TICK_DIV(16),
    .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .move_left(move_left),
    .move_right(move_right),
    .x_pos(x_pos),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .vga_plot(vga_plot),
    .busy(busy)
  );

  function automatic rec_t mk(bit p, int x, int y,
                              logic [2:0] c, bit b, int xp);
    rec_t r;
    r.plot = p;
    r.x    = 8'(x);
    r.y    = 7'(y);
    r.col  = c;
    r.busy = b;
    r.xpos = 8'(xp);
    return r;
  endfunction

  // A full 2x2 sprite pass at column xp, row 3.
  function automatic void push_sprite(int xp, logic [2:0] c, int xr);
    for (int k = 0; k < 4; k++)
      q.push_back(mk(1'b1, xp + k % 2, 3 + k / 2, c, 1'b1, xr));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    rec_t e, o;
    int   tgt;
    @(negedge clk);
    if (q.size() > 0) e = q.pop_front();
    else              e = mk(1'b0, 0, 0, BG, 1'b0, ref_x);
    o.plot = vga_plot;
    o.x    = vga_x;
    o.y    = vga_y;
    o.col  = vga_colour;
    o.busy = busy;
    o.xpos = x_pos;
    if (known) begin
      n_chk++;
      assert (o === e) n_pass++;
      else $error("FAIL cyc%0d: got p=%b x=%0d y=%0d c=%0d b=%b xp=%0d expected p=%b x=%0d y=%0d c=%0d b=%b xp=%0d",
                  cyc, o.plot, o.x, o.y, o.col, o.busy, o.xpos,
                  e.plot, e.x, e.y, e.col, e.busy, e.xpos);
    end
    if (!resetn) begin
      q.delete();
      q.push_back(mk(1'b0, 0, 0, BG, 1'b1, 5));
      push_sprite(5, FG, 5);
      ref_x = 5;
      ph    = 0;
      known = 1'b1;
    end else begin
      if (!e.busy && ph == 15) begin
        tgt = ref_x;
        if (move_left && !move_right)
          tgt = (ref_x - 1 < 2) ? 2 : ref_x - 1;
        else if (move_right && !move_left)
          tgt = (ref_x + 1 > 10) ? 10 : ref_x + 1;
        if (tgt != ref_x) begin
          push_sprite(ref_x, BG, ref_x);
          q.push_back(mk(1'b0, 0, 0, BG, 1'b1, ref_x));
          push_sprite(tgt, FG, tgt);
          ref_x = tgt;
        end
      end
      ph = (ph + 1) % 16;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit l, input bit r);
    move_left  = l;
    move_right = r;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset and idle after the initial draw
    resetn = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    run(40, 1'b0, 1'b0);
    chk("idle_xpos", 32'(x_pos), 5);
    chk("idle_busy", 32'(busy), 0);

    // Move right for three ticks
    run(48, 1'b0, 1'b1);
    run(16, 1'b0, 1'b0);
    chk("right3", 32'(x_pos), 8);

    // Move left down to the lower clamp
    run(80, 1'b1, 1'b0);
    run(16, 1'b0, 1'b0);
    chk("left5", 32'(x_pos), 3);
    run(48, 1'b1, 1'b0);
    run(16, 1'b0, 1'b0);
    chk("left_clamp", 32'(x_pos), 2);

    // Both keys: no motion
    run(48, 1'b1, 1'b1);
    chk("both_xpos", 32'(x_pos), 2);
    chk("both_busy", 32'(busy), 0);

    // Keys toggled only off the tick cycle
    for (int i = 0; i < 64; i++) begin
      move_left  = (ph != 15) ? 1'($urandom % 2) : 1'b0;
      move_right = (ph != 15) ? 1'($urandom % 2) : 1'b0;
      cycle();
    end
    chk("offtick_xpos", 32'(x_pos), 2);

    // Key present only on the tick cycle
    move_left  = 1'b0;
    move_right = 1'b0;
    while (ph != 15) cycle();
    move_right = 1'b1;
    cycle();
    run(16, 1'b0, 1'b0);
    chk("ontick_xpos", 32'(x_pos), 3);

    // Reset during the second erase pixel
    while (ph != 15) cycle();
    move_right = 1'b1;
    cycle();
    move_right = 1'b0;
    cycle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    chk("abort_plot", 32'(vga_plot), 0);
    chk("abort_xpos", 32'(x_pos), 5);
    chk("abort_busy", 32'(busy), 1);
    run(20, 1'b0, 1'b0);
    chk("abort_redraw", 32'(x_pos), 5);

    // Random keys with occasional resets
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        move_left  = 1'($urandom % 2);
        move_right = 1'($urandom % 2);
      end
      if ($urandom_range(0, 7) == 0) move_left = ~move_left;
      resetn = ($urandom_range(0, 199) != 0);
      cycle();
    end
    resetn = 1'b1;
    run(30, 1'b0, 1'b0);
    chk("final_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
